execute_issue_arbiter: RTL and testbench

- Shares the single execute stage (scalar ALU plus vector lane ALU, selected by isScalarInstruction) between two issue sources: a scalar issue port and a vector issue port.
- Each source uses a valid/ready handshake. The block arbitrates round-robin and drives a one-entry registered issue slot that feeds the execute stage.
- Sits between decode/register-read and execute. It also supports a pipeline flush.

---
 rtl/execute_pkg.sv | 31 +++
 rtl/execute_issue_arbiter_rr_arbiter2.sv | 38 +++
 rtl/execute_issue_arbiter.sv | 136 +++++++++++++
 tb/tb_execute_issue_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared types and default widths for the execute issue arbiter.
// The issue_slot_t layout follows the DEF_* widths below.
package execute_pkg;

  localparam int unsigned DEF_SCALAR_DATA_WIDTH = 48;
  localparam int unsigned DEF_VECTOR_DATA_WIDTH = 8;
  localparam int unsigned DEF_VECTOR_SIZE       = 6;
  localparam int unsigned DEF_TAG_WIDTH         = 4;
  localparam int unsigned DEF_MAX_WAIT          = 7;
  localparam int unsigned ALU_CTRL_WIDTH        = 3;
  localparam int unsigned GRANT_COUNT_WIDTH     = 8;

  typedef enum logic {
    GRANT_SCALAR = 1'b0,
    GRANT_VECTOR = 1'b1
  } grant_e;

  typedef logic [DEF_SCALAR_DATA_WIDTH-1:0]                       sdata_t;
  typedef logic [DEF_VECTOR_SIZE-1:0][DEF_VECTOR_DATA_WIDTH-1:0] vdata_t;

  typedef struct packed {
    logic [ALU_CTRL_WIDTH-1:0] aluControl;
    logic                      isScalar;
    logic [DEF_TAG_WIDTH-1:0]  tag;
    sdata_t                    sData1;
    sdata_t                    sData2;
    vdata_t                    vOperand1;
    vdata_t                    vOperand2;
  } issue_slot_t;

endpackage

// File: rtl/execute_issue_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: on contention the source not granted last wins.
// Grants are combinational; the last-grant state updates only on an actual grant.
module rr_arbiter2
  import execute_pkg::*;
(
  input  logic clk,
  input  logic nReset,
  input  logic i_en,
  input  logic i_flush,
  input  logic i_req_s,
  input  logic i_req_v,
  output logic o_gnt_s_c,
  output logic o_gnt_v_c
);

  grant_e r_last_grant;
  logic   w_pick_v;
  logic   w_go;

  always_comb begin
    w_go      = i_en && !i_flush;
    w_pick_v  = i_req_v && (!i_req_s || (r_last_grant == GRANT_SCALAR));
    o_gnt_v_c = w_go && w_pick_v;
    o_gnt_s_c = w_go && i_req_s && !w_pick_v;
  end

  // Reset to vector so the first contended grant goes to scalar.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_last_grant <= GRANT_VECTOR;
    end else if (o_gnt_v_c) begin
      r_last_grant <= GRANT_VECTOR;
    end else if (o_gnt_s_c) begin
      r_last_grant <= GRANT_SCALAR;
    end
  end

endmodule

// File: rtl/execute_issue_arbiter.sv
// Arbitrates scalar and vector issue ports into one registered execute issue slot.
// EXECUTE_SCALAR_PRIORITY_EN selects fixed scalar priority with a vector starvation limit.
module execute_issue_arbiter
  import execute_pkg::*;
#(
  parameter int unsigned SCALAR_DATA_WIDTH = DEF_SCALAR_DATA_WIDTH,
  parameter int unsigned VECTOR_DATA_WIDTH = DEF_VECTOR_DATA_WIDTH,
  parameter int unsigned VECTOR_SIZE       = DEF_VECTOR_SIZE,
  parameter int unsigned TAG_WIDTH         = DEF_TAG_WIDTH,
  parameter int unsigned MAX_WAIT          = DEF_MAX_WAIT
) (
  input  logic                                             clk,
  input  logic                                             nReset,
  input  logic                                             flush,
  input  logic                                             sValid,
  output logic                                             sReady,
  input  logic [SCALAR_DATA_WIDTH-1:0]                     sData1,
  input  logic [SCALAR_DATA_WIDTH-1:0]                     sData2,
  input  logic [ALU_CTRL_WIDTH-1:0]                        sAluControl,
  input  logic [TAG_WIDTH-1:0]                             sTag,
  input  logic                                             vValid,
  output logic                                             vReady,
  input  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]    vOperand1,
  input  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]    vOperand2,
  input  logic [ALU_CTRL_WIDTH-1:0]                        vAluControl,
  input  logic [TAG_WIDTH-1:0]                             vTag,
  output logic                                             outValid,
  input  logic                                             outReady,
  output logic [SCALAR_DATA_WIDTH-1:0]                     outScalarData1,
  output logic [SCALAR_DATA_WIDTH-1:0]                     outScalarData2,
  output logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]    outVectorOperand1,
  output logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]    outVectorOperand2,
  output logic [ALU_CTRL_WIDTH-1:0]                        outAluControl,
  output logic                                             outIsScalar,
  output logic [TAG_WIDTH-1:0]                             outTag,
  output logic [GRANT_COUNT_WIDTH-1:0]                     grantCount
);

  logic                         r_out_valid;
  issue_slot_t                  r_slot;
  logic [GRANT_COUNT_WIDTH-1:0] r_grant_count;
  issue_slot_t                  w_load;
  logic                         w_slot_free;
  logic                         w_gnt_s;
  logic                         w_gnt_v;

  assign w_slot_free = !r_out_valid || outReady;

`ifdef EXECUTE_SCALAR_PRIORITY_EN
  localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [WAIT_W-1:0] r_wait;
  logic              w_force_v;
  logic              w_go;

  // Scalar wins contention unless the vector side has waited MAX_WAIT cycles.
  always_comb begin
    w_go      = w_slot_free && !flush;
    w_force_v = (r_wait == WAIT_W'(MAX_WAIT));
    w_gnt_v   = w_go && vValid && (w_force_v || !sValid);
    w_gnt_s   = w_go && sValid && !w_gnt_v;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_wait <= '0;
    end else if (flush || w_gnt_v) begin
      r_wait <= '0;
    end else if (vValid && !w_force_v) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end
`else
  logic w_unused_max_wait;
  assign w_unused_max_wait = ^32'(MAX_WAIT);

  rr_arbiter2 u_rr_arbiter2 (
    .clk       (clk),
    .nReset    (nReset),
    .i_en      (w_slot_free),
    .i_flush   (flush),
    .i_req_s   (sValid),
    .i_req_v   (vValid),
    .o_gnt_s_c (w_gnt_s),
    .o_gnt_v_c (w_gnt_v)
  );
`endif

  assign sReady = w_gnt_s;
  assign vReady = w_gnt_v;

  // Slot image for the granted source; fields of the other kind load as zero.
  always_comb begin
    w_load = '0;
    if (w_gnt_s) begin
      w_load.aluControl = sAluControl;
      w_load.isScalar   = 1'b1;
      w_load.tag        = sTag;
      w_load.sData1     = sData1;
      w_load.sData2     = sData2;
    end else begin
      w_load.aluControl = vAluControl;
      w_load.tag        = vTag;
      w_load.vOperand1  = vOperand1;
      w_load.vOperand2  = vOperand2;
    end
  end

  // Flush beats both a new grant and consumption; data holds when not reloaded.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_out_valid   <= 1'b0;
      r_slot        <= '0;
      r_grant_count <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_gnt_s || w_gnt_v) begin
      r_out_valid   <= 1'b1;
      r_slot        <= w_load;
      r_grant_count <= r_grant_count + GRANT_COUNT_WIDTH'(1);
    end else if (outReady) begin
      r_out_valid <= 1'b0;
    end
  end

  assign outValid          = r_out_valid;
  assign outScalarData1    = r_slot.sData1;
  assign outScalarData2    = r_slot.sData2;
  assign outVectorOperand1 = r_slot.vOperand1;
  assign outVectorOperand2 = r_slot.vOperand2;
  assign outAluControl     = r_slot.aluControl;
  assign outIsScalar       = r_slot.isScalar;
  assign outTag            = r_slot.tag;
  assign grantCount        = r_grant_count;

endmodule

// File: tb/tb_execute_issue_arbiter.sv
// Self-checking bench for execute_issue_arbiter: vector table plus issue-slot scoreboard.
// Covers both builds; EXECUTE_SCALAR_PRIORITY_EN switches the contention sequence.
module tb_execute_issue_arbiter;

  logic              clk;
  logic              nReset;
  logic              flush;
  logic              sValid;
  logic              sReady;
  logic [47:0]       sData1;
  logic [47:0]       sData2;
  logic [2:0]        sAluControl;
  logic [3:0]        sTag;
  logic              vValid;
  logic              vReady;
  logic [5:0][7:0]   vOperand1;
  logic [5:0][7:0]   vOperand2;
  logic [2:0]        vAluControl;
  logic [3:0]        vTag;
  logic              outValid;
  logic              outReady;
  logic [47:0]       outScalarData1;
  logic [47:0]       outScalarData2;
  logic [5:0][7:0]   outVectorOperand1;
  logic [5:0][7:0]   outVectorOperand2;
  logic [2:0]        outAluControl;
  logic              outIsScalar;
  logic [3:0]        outTag;
  logic [7:0]        grantCount;

  execute_issue_arbiter #(
    .SCALAR_DATA_WIDTH (48),
    .VECTOR_DATA_WIDTH (8),
    .VECTOR_SIZE       (6),
    .TAG_WIDTH         (4),
    .MAX_WAIT          (3)
  ) dut (
    .clk               (clk),
    .nReset            (nReset),
    .flush             (flush),
    .sValid            (sValid),
    .sReady            (sReady),
    .sData1            (sData1),
    .sData2            (sData2),
    .sAluControl       (sAluControl),
    .sTag              (sTag),
    .vValid            (vValid),
    .vReady            (vReady),
    .vOperand1         (vOperand1),
    .vOperand2         (vOperand2),
    .vAluControl       (vAluControl),
    .vTag              (vTag),
    .outValid          (outValid),
    .outReady          (outReady),
    .outScalarData1    (outScalarData1),
    .outScalarData2    (outScalarData2),
    .outVectorOperand1 (outVectorOperand1),
    .outVectorOperand2 (outVectorOperand2),
    .outAluControl     (outAluControl),
    .outIsScalar       (outIsScalar),
    .outTag            (outTag),
    .grantCount        (grantCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       sv;
    logic       vv;
    logic       ordy;
    logic [3:0] st;
    logic [3:0] vt;
    logic       esr;
    logic       evr;
    logic [7:0] ecnt;
  } vec_rec_t;

  typedef struct {
    logic        is_s;
    logic [3:0]  tag;
    logic [2:0]  alu;
    logic [47:0] d1;
    logic [47:0] d2;
    logic [47:0] v1;
    logic [47:0] v2;
  } exp_t;

  exp_t     sb_q[$];
  vec_rec_t tbl[$];
  int       n_checks = 0;
  int       n_err    = 0;
  int       base_cnt;

  function automatic logic [47:0] sd(input logic [3:0] t);
    return {12{t}};
  endfunction

  function automatic logic [47:0] vo1(input logic [3:0] t);
    logic [47:0] r;
    for (int i = 0; i < 6; i++) r[i*8 +: 8] = {t, 4'(i)};
    return r;
  endfunction

  function automatic logic [47:0] vo2(input logic [3:0] t);
    logic [47:0] r;
    for (int i = 0; i < 6; i++) r[i*8 +: 8] = {4'(i), ~t};
    return r;
  endfunction

  function automatic vec_rec_t mk(input logic fl, input logic sv, input logic vv, input logic ordy,
                                  input int st, input int vt, input logic esr, input logic evr,
                                  input int ecnt);
    vec_rec_t r;
    r.fl = fl; r.sv = sv; r.vv = vv; r.ordy = ordy;
    r.st = 4'(st); r.vt = 4'(vt);
    r.esr = esr; r.evr = evr; r.ecnt = 8'(ecnt);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // One cycle: drive at negedge, check readies, then check the slot after the posedge.
  task automatic apply(input vec_rec_t r);
    logic       consumed;
    exp_t       e;
    logic [2:0] valu;
    @(negedge clk);
    flush       = r.fl;
    sValid      = r.sv;
    vValid      = r.vv;
    outReady    = r.ordy;
    sTag        = r.st;
    vTag        = r.vt;
    sData1      = sd(r.st);
    sData2      = ~sd(r.st);
    sAluControl = r.st[2:0];
    valu        = ~r.vt[2:0];
    vAluControl = valu;
    vOperand1   = vo1(r.vt);
    vOperand2   = vo2(r.vt);
    #1;
    chk("sReady", 64'(sReady), 64'(r.esr));
    chk("vReady", 64'(vReady), 64'(r.evr));
    consumed = (sb_q.size() > 0) && (r.ordy || r.fl);
    @(posedge clk);
    #1;
    if (consumed) void'(sb_q.pop_front());
    if (r.esr) begin
      e.is_s = 1'b1; e.tag = r.st; e.alu = r.st[2:0];
      e.d1 = sd(r.st); e.d2 = ~sd(r.st); e.v1 = '0; e.v2 = '0;
      sb_q.push_back(e);
    end else if (r.evr) begin
      e.is_s = 1'b0; e.tag = r.vt; e.alu = valu;
      e.d1 = '0; e.d2 = '0; e.v1 = vo1(r.vt); e.v2 = vo2(r.vt);
      sb_q.push_back(e);
    end
    chk("grantCount", 64'(grantCount), 64'(r.ecnt));
    if (sb_q.size() > 0) begin
      e = sb_q[0];
      chk("outValid", 64'(outValid), 64'(1'b1));
      chk("outIsScalar", 64'(outIsScalar), 64'(e.is_s));
      chk("outTag", 64'(outTag), 64'(e.tag));
      chk("outAluControl", 64'(outAluControl), 64'(e.alu));
      chk("outScalarData1", 64'(outScalarData1), 64'(e.d1));
      chk("outScalarData2", 64'(outScalarData2), 64'(e.d2));
      chk("outVectorOperand1", 64'(outVectorOperand1), 64'(e.v1));
      chk("outVectorOperand2", 64'(outVectorOperand2), 64'(e.v2));
    end else begin
      chk("outValid_idle", 64'(outValid), 64'(1'b0));
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; sValid = 1'b0; vValid = 1'b0; outReady = 1'b0;
    sTag = '0; vTag = '0; sData1 = '0; sData2 = '0; sAluControl = '0;
    vAluControl = '0; vOperand1 = '0; vOperand2 = '0;
  endtask

  task automatic check_reset_state(input string tagname);
    chk({tagname, "_outValid"}, 64'(outValid), 64'(1'b0));
    chk({tagname, "_grantCount"}, 64'(grantCount), 64'(8'd0));
    chk({tagname, "_outIsScalar"}, 64'(outIsScalar), 64'(1'b0));
    chk({tagname, "_outTag"}, 64'(outTag), 64'(4'd0));
    chk({tagname, "_outAluControl"}, 64'(outAluControl), 64'(3'd0));
    chk({tagname, "_outScalarData1"}, 64'(outScalarData1), 64'(48'd0));
    chk({tagname, "_outVectorOperand1"}, 64'(outVectorOperand1), 64'(48'd0));
  endtask

  initial begin
    nReset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(posedge clk);
    #2;
    nReset = 1'b1;

`ifndef EXECUTE_SCALAR_PRIORITY_EN
    // fl sv vv or st vt | sReady vReady grantCount
    tbl.push_back(mk(0,1,1,1, 1, 2, 1,0, 1));   // first contended grant: scalar
    tbl.push_back(mk(0,1,1,1, 3, 2, 0,1, 2));
    tbl.push_back(mk(0,1,1,1, 3, 4, 1,0, 3));
    tbl.push_back(mk(0,1,1,1, 5, 4, 0,1, 4));
    tbl.push_back(mk(0,0,1,0, 0, 5, 0,0, 4));   // backpressure, slot held
    tbl.push_back(mk(0,0,1,0, 0, 5, 0,0, 4));
    tbl.push_back(mk(0,0,1,0, 0, 5, 0,0, 4));
    tbl.push_back(mk(0,0,1,1, 0, 5, 0,1, 5));   // vector tag 5 loads as old op leaves
    tbl.push_back(mk(1,1,1,0, 7, 8, 0,0, 5));   // flush kills held slot
    tbl.push_back(mk(0,1,1,0, 7, 8, 1,0, 6));   // lastGrant untouched by flush
    tbl.push_back(mk(0,0,0,1, 0, 0, 0,0, 6));
    tbl.push_back(mk(0,0,0,0, 0, 0, 0,0, 6));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0,0,1,1, 0, 9+i, 0,1, 7+i));
    tbl.push_back(mk(0,0,0,1, 0, 0, 0,0, 12));
    tbl.push_back(mk(0,1,0,1, 15, 0, 1,0, 13));
    tbl.push_back(mk(1,1,1,1, 1, 1, 0,0, 13));  // flush beats grant and outReady
    tbl.push_back(mk(0,1,1,1, 2, 3, 0,1, 14));
    tbl.push_back(mk(0,1,0,1, 2, 0, 1,0, 15));
    tbl.push_back(mk(0,0,0,1, 0, 0, 0,0, 15));
    base_cnt = 15;
`else
    // Starvation limit 3: S,S,S,V repeating with both sources held.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0,1,1,1, i, i+8, (i % 4) != 3, (i % 4) == 3, i+1));
    tbl.push_back(mk(0,0,0,1, 0, 0, 0,0, 8));
    base_cnt = 8;
`endif
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Long vector-only stream, wraps grantCount through 255 -> 0.
    for (int i = 0; i < 250; i++) apply(mk(0,0,1,1, 0, i % 16, 0,1, base_cnt + i + 1));

    // Asynchronous reset mid-operation with a valid slot.
    @(negedge clk);
    #2;
    nReset = 1'b0;
    #1;
    check_reset_state("midreset");
    sb_q.delete();
    idle_inputs();
    @(posedge clk);
    #2;
    nReset = 1'b1;
    apply(mk(0,1,1,1, 6, 9, 1,0, 1));
    apply(mk(0,0,0,1, 0, 0, 0,0, 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
